// File: rtl/uart_mem_loader.sv
// uart_mem_loader
//   Packs a stream of received bytes into memory words and writes NUM_WORDS
//   words starting at BASE_ADDR. A single-entry write buffer sits between the
//   byte assembler and the memory port, so a finished word can be handed off
//   while the next one is assembled. A partial word left idle for
//   IDLE_TIMEOUT cycles is flushed with only its filled lanes enabled.
//
// Ports
//   clock, reset       sole clock (rising edge); synchronous active-high reset
//   start              begin or restart a load session (any state)
//   rx_valid, rx_data  one received byte per cycle in which rx_valid is high
//   mem_en, mem_we     write request and per-lane byte enables
//   mem_addr           byte address of the buffered word
//   mem_wdata          buffered word
//   mem_ready          memory accepts the request this cycle
//   busy, done         session collecting / session complete
//   overrun            sticky: a word-completing byte was dropped
//   words_written      number of writes accepted this session
module uart_mem_loader #(
  parameter int                WORD_BYTES   = 4,
  parameter int                NUM_WORDS    = 8,
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
  parameter int                BIG_ENDIAN   = 0,
  parameter int                IDLE_TIMEOUT = 16,
  localparam int               DW           = 8 * WORD_BYTES,
  localparam int               WC_W         = $clog2(NUM_WORDS + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              mem_en,
  output logic [WORD_BYTES-1:0] mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DW-1:0]     mem_wdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic              overrun,
  output logic [WC_W-1:0]   words_written
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  // Idle counter must hold IDLE_TIMEOUT itself (it saturates there).
  localparam int              IW        = $clog2(IDLE_TIMEOUT + 2);
  localparam logic [IW-1:0]   IDLE_LIM  = IW'(IDLE_TIMEOUT);
  localparam logic [3:0]      LAST_IDX  = 4'(WORD_BYTES - 1);
  localparam logic [WC_W-1:0] LAST_WORD = WC_W'(NUM_WORDS - 1);
  localparam logic [WC_W-1:0] ALL_WORDS = WC_W'(NUM_WORDS);

  logic [1:0]            state_reg, state_next;
  logic [3:0]            byte_idx_reg, byte_idx_next;
  logic [DW-1:0]         asm_reg, asm_next;
  logic                  buf_valid_reg, buf_valid_next;
  logic [DW-1:0]         buf_data_reg, buf_data_next;
  logic [WORD_BYTES-1:0] buf_we_reg, buf_we_next;
  logic [WC_W-1:0]       word_idx_reg, word_idx_next;
  logic [WC_W-1:0]       entered_reg, entered_next;
  logic [IW-1:0]         idle_cnt_reg, idle_cnt_next;
  logic                  overrun_reg, overrun_next;

  logic [3:0]            lane_sel;
  logic [DW-1:0]         asm_ins;
  logic [WORD_BYTES-1:0] fill_mask;
  logic                  accept;
  logic                  buf_free;
  logic                  room;
  logic                  last_lane;
  logic                  idle_due;

  // Lane receiving the byte at the current arrival position.
  assign lane_sel = (BIG_ENDIAN != 0) ? (LAST_IDX - byte_idx_reg) : byte_idx_reg;

  genvar gi;
  generate
    for (gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
      // Arrival order of the byte that lands in lane gi.
      localparam logic [3:0] POS = (BIG_ENDIAN != 0) ? 4'(WORD_BYTES - 1 - gi) : 4'(gi);
      assign asm_ins[gi*8 +: 8] = (lane_sel == 4'(gi)) ? rx_data : asm_reg[gi*8 +: 8];
      assign fill_mask[gi]      = (POS < byte_idx_reg);
    end
  endgenerate

  assign accept    = buf_valid_reg && mem_ready;
  // The buffer can take a new word if empty or if it empties this very cycle.
  assign buf_free  = !buf_valid_reg || mem_ready;
  assign room      = (entered_reg < ALL_WORDS);
  assign last_lane = (byte_idx_reg == LAST_IDX);
  // This cycle is the IDLE_TIMEOUT-th consecutive idle cycle (or later, when
  // the counter has saturated waiting for the buffer).
  assign idle_due  = (IDLE_TIMEOUT > 0) && !rx_valid && (byte_idx_reg != 4'd0) &&
                     ((idle_cnt_reg + IW'(1)) >= IDLE_LIM);

  always_comb begin
    state_next     = state_reg;
    byte_idx_next  = byte_idx_reg;
    asm_next       = asm_reg;
    buf_valid_next = buf_valid_reg;
    buf_data_next  = buf_data_reg;
    buf_we_next    = buf_we_reg;
    word_idx_next  = word_idx_reg;
    entered_next   = entered_reg;
    idle_cnt_next  = idle_cnt_reg;
    overrun_next   = overrun_reg;

    case (state_reg)
      COLLECT: begin
        if (accept) begin
          buf_valid_next = 1'b0;
          buf_we_next    = '0;
          word_idx_next  = word_idx_reg + WC_W'(1);
          if (word_idx_reg == LAST_WORD) begin
            state_next = DONE;
          end
        end

        if (rx_valid) begin
          idle_cnt_next = '0;
          if (room) begin
            if (!last_lane) begin
              asm_next      = asm_ins;
              byte_idx_next = byte_idx_reg + 4'd1;
            end else if (buf_free) begin
              buf_valid_next = 1'b1;
              buf_data_next  = asm_ins;
              buf_we_next    = '1;
              asm_next       = '0;
              byte_idx_next  = 4'd0;
              entered_next   = entered_reg + WC_W'(1);
            end else begin
              // Word-completing byte with nowhere to go: drop it.
              overrun_next = 1'b1;
            end
          end
        end else begin
          if (idle_cnt_reg < IDLE_LIM) begin
            idle_cnt_next = idle_cnt_reg + IW'(1);
          end
          if (idle_due && buf_free) begin
            // Unfilled lanes of asm_reg are already zero.
            buf_valid_next = 1'b1;
            buf_data_next  = asm_reg;
            buf_we_next    = fill_mask;
            asm_next       = '0;
            byte_idx_next  = 4'd0;
            entered_next   = entered_reg + WC_W'(1);
            idle_cnt_next  = '0;
          end
        end
      end
      default: begin
      end
    endcase

    if (start) begin
      state_next     = COLLECT;
      byte_idx_next  = 4'd0;
      asm_next       = '0;
      buf_valid_next = 1'b0;
      buf_data_next  = '0;
      buf_we_next    = '0;
      word_idx_next  = '0;
      entered_next   = '0;
      idle_cnt_next  = '0;
      overrun_next   = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      byte_idx_reg  <= 4'd0;
      asm_reg       <= '0;
      buf_valid_reg <= 1'b0;
      buf_data_reg  <= '0;
      buf_we_reg    <= '0;
      word_idx_reg  <= '0;
      entered_reg   <= '0;
      idle_cnt_reg  <= '0;
      overrun_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      byte_idx_reg  <= byte_idx_next;
      asm_reg       <= asm_next;
      buf_valid_reg <= buf_valid_next;
      buf_data_reg  <= buf_data_next;
      buf_we_reg    <= buf_we_next;
      word_idx_reg  <= word_idx_next;
      entered_reg   <= entered_next;
      idle_cnt_reg  <= idle_cnt_next;
      overrun_reg   <= overrun_next;
    end
  end

  // The buffered word always belongs to the next unaccepted word index.
  assign mem_addr      = BASE_ADDR + ADDR_W'(word_idx_reg) * ADDR_W'(WORD_BYTES);
  assign mem_en        = buf_valid_reg;
  assign mem_we        = buf_we_reg;
  assign mem_wdata     = buf_data_reg;
  assign busy          = (state_reg == COLLECT);
  assign done          = (state_reg == DONE);
  assign overrun       = overrun_reg;
  assign words_written = word_idx_reg;

endmodule

// File: tb/tb_uart_mem_loader.sv
// Testbench for uart_mem_loader: a little-endian instance (BASE 0) and a
// big-endian instance (BASE 0x100) share all stimulus.
module tb_uart_mem_loader;

  logic        clk = 1'b0;
  logic        reset, start, rx_valid, mem_ready;
  logic [7:0]  rx_data;

  logic        mem_en, busy, done, overrun;
  logic [3:0]  mem_we, words_written;
  logic [31:0] mem_addr, mem_wdata;

  logic        be_mem_en, be_busy, be_done, be_overrun;
  logic [3:0]  be_mem_we, be_words_written;
  logic [31:0] be_mem_addr, be_mem_wdata;

  always #5 clk = ~clk;

  uart_mem_loader dut (
    .clock(clk), .reset(reset), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .busy(busy), .done(done), .overrun(overrun),
    .words_written(words_written)
  );

  uart_mem_loader #(.BIG_ENDIAN(1), .BASE_ADDR(32'h100)) dut_be (
    .clock(clk), .reset(reset), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
    .mem_en(be_mem_en), .mem_we(be_mem_we), .mem_addr(be_mem_addr), .mem_wdata(be_mem_wdata),
    .mem_ready(mem_ready), .busy(be_busy), .done(be_done), .overrun(be_overrun),
    .words_written(be_words_written)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  we;
  } wr_t;

  typedef struct {
    int          nbytes;
    int          gap;
    int          exp_writes;
    int          exp_ww;
    logic        exp_done;
    logic [31:0] exp_first;
    logic [31:0] exp_first_be;
    logic [31:0] exp_last;
    logic [3:0]  exp_last_we;
    logic [31:0] exp_last_addr;
  } vec_t;

  wr_t wq[$];
  wr_t bq[$];
  int  en_count;
  int  checks = 0;
  int  errors = 0;

  // Reference model state for the randomized sessions.
  wr_t        mq_le[$];
  wr_t        mq_be[$];
  logic [7:0] part_q[$];
  logic [7:0] rnd_bytes[$];
  int         rnd_gaps[$];
  int         model_nw;

  vec_t tab[7];

  // Accepted writes, captured mid-cycle.
  always @(negedge clk) begin
    if (mem_en) en_count++;
    if (mem_en && mem_ready) begin
      wq.push_back('{mem_addr, mem_wdata, mem_we});
      $display("[%0t] le write addr=%08h data=%08h we=%h", $time, mem_addr, mem_wdata, mem_we);
    end
    if (be_mem_en && mem_ready) begin
      bq.push_back('{be_mem_addr, be_mem_wdata, be_mem_we});
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    wq.delete();
    bq.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic run_vec(input int i, input vec_t v);
    do_start();
    chk($sformatf("v%0d_start_busy", i), 64'(busy), 64'd1);
    chk($sformatf("v%0d_start_done", i), 64'(done), 64'd0);
    chk($sformatf("v%0d_start_ww", i), 64'(words_written), 64'd0);
    for (int k = 0; k < v.nbytes; k++) send(8'(k), v.gap);
    repeat (40) tick();
    chk($sformatf("v%0d_writes", i), 64'(wq.size()), 64'(v.exp_writes));
    chk($sformatf("v%0d_ww", i), 64'(words_written), 64'(v.exp_ww));
    chk($sformatf("v%0d_done", i), 64'(done), 64'(v.exp_done));
    chk($sformatf("v%0d_overrun", i), 64'(overrun), 64'd0);
    if (wq.size() > 0 && bq.size() > 0) begin
      chk($sformatf("v%0d_first_data", i), 64'(wq[0].data), 64'(v.exp_first));
      chk($sformatf("v%0d_first_addr", i), 64'(wq[0].addr), 64'd0);
      chk($sformatf("v%0d_first_be_data", i), 64'(bq[0].data), 64'(v.exp_first_be));
      chk($sformatf("v%0d_first_be_addr", i), 64'(bq[0].addr), 64'h100);
      chk($sformatf("v%0d_last_data", i), 64'(wq[wq.size()-1].data), 64'(v.exp_last));
      chk($sformatf("v%0d_last_we", i), 64'(wq[wq.size()-1].we), 64'(v.exp_last_we));
      chk($sformatf("v%0d_last_addr", i), 64'(wq[wq.size()-1].addr), 64'(v.exp_last_addr));
    end
  endtask

  // Turns the pending bytes of the model into one expected write per endianness.
  function automatic void model_emit();
    logic [31:0] dl = '0;
    logic [31:0] db = '0;
    logic [3:0]  wl = '0;
    logic [3:0]  wb = '0;
    for (int k = 0; k < part_q.size(); k++) begin
      dl = dl | (32'(part_q[k]) << (8 * k));
      db = db | (32'(part_q[k]) << (8 * (3 - k)));
      wl[k] = 1'b1;
      wb[3-k] = 1'b1;
    end
    mq_le.push_back('{32'(model_nw * 4), dl, wl});
    mq_be.push_back('{32'h100 + 32'(model_nw * 4), db, wb});
    model_nw++;
    part_q.delete();
  endfunction

  initial begin
    //                nb gap wr ww done first         first_be      last          we    last_addr
    tab[0] = '{32, 0, 8, 8, 1'b1, 32'h03020100, 32'h00010203, 32'h1F1E1D1C, 4'hF, 32'h1C};
    tab[1] = '{36, 1, 8, 8, 1'b1, 32'h03020100, 32'h00010203, 32'h1F1E1D1C, 4'hF, 32'h1C};
    tab[2] = '{ 2, 0, 1, 1, 1'b0, 32'h00000100, 32'h00010000, 32'h00000100, 4'h3, 32'h00};
    tab[3] = '{13, 2, 4, 4, 1'b0, 32'h03020100, 32'h00010203, 32'h0000000C, 4'h1, 32'h0C};
    tab[4] = '{ 7, 15, 2, 2, 1'b0, 32'h03020100, 32'h00010203, 32'h00060504, 4'h7, 32'h04};
    tab[5] = '{29, 3, 8, 8, 1'b1, 32'h03020100, 32'h00010203, 32'h0000001C, 4'h1, 32'h1C};
    tab[6] = '{ 6, 16, 6, 6, 1'b0, 32'h00000000, 32'h00000000, 32'h00000005, 4'h1, 32'h14};

    reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; mem_ready = 1'b1;
    en_count = 0;
    repeat (3) tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_overrun", 64'(overrun), 64'd0);
    chk("rst_mem_en", 64'(mem_en), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_ww", 64'(words_written), 64'd0);
    chk("rst_be_addr", 64'(be_mem_addr), 64'h100);

    // Reset wins over start.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rst_over_start_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    tick();

    // Bytes in IDLE are ignored.
    en_count = 0;
    for (int k = 0; k < 6; k++) send(8'(k + 8'h40), 0);
    repeat (30) tick();
    chk("idle_ignore_en", 64'(en_count), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);

    // Table of whole sessions with fixed byte spacing.
    for (int i = 0; i < 7; i++) run_vec(i, tab[i]);

    // Big-endian lane order.
    do_start();
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
    repeat (5) tick();
    chk("be_count", 64'(bq.size()), 64'd1);
    if (bq.size() > 0 && wq.size() > 0) begin
      chk("be_data", 64'(bq[0].data), 64'h11223344);
      chk("be_we", 64'(bq[0].we), 64'hF);
      chk("be_addr", 64'(bq[0].addr), 64'h100);
      chk("le_data_same_bytes", 64'(wq[0].data), 64'h44332211);
    end

    // Idle flush of a partial word, then the next byte starts a new word.
    do_start();
    send(8'hAA, 0); send(8'hBB, 0);
    repeat (13) tick();
    chk("flush_not_early", 64'(wq.size()), 64'd0);
    repeat (10) tick();
    chk("flush_count", 64'(wq.size()), 64'd1);
    send(8'hCC, 0); send(8'hDD, 0);
    repeat (30) tick();
    chk("flush_count2", 64'(wq.size()), 64'd2);
    if (wq.size() == 2) begin
      chk("flush_data", 64'(wq[0].data), 64'h0000BBAA);
      chk("flush_we", 64'(wq[0].we), 64'h3);
      chk("flush_addr", 64'(wq[0].addr), 64'h0);
      chk("flush2_data", 64'(wq[1].data), 64'h0000DDCC);
      chk("flush2_addr", 64'(wq[1].addr), 64'h4);
    end

    // Memory stalled: the 8th byte would complete a word behind a full buffer.
    mem_ready = 1'b0;
    do_start();
    for (int k = 0; k < 8; k++) send(8'(k), 0);
    repeat (12) tick();
    chk("stall_overrun", 64'(overrun), 64'd1);
    chk("stall_no_write", 64'(wq.size()), 64'd0);
    chk("stall_mem_en", 64'(mem_en), 64'd1);
    mem_ready = 1'b1;
    repeat (40) tick();
    chk("stall_count", 64'(wq.size()), 64'd2);
    if (wq.size() == 2) begin
      chk("stall_w0_addr", 64'(wq[0].addr), 64'h0);
      chk("stall_w0_data", 64'(wq[0].data), 64'h03020100);
      chk("stall_w1_addr", 64'(wq[1].addr), 64'h4);
      chk("stall_w1_data", 64'(wq[1].data), 64'h00060504);
      chk("stall_w1_we", 64'(wq[1].we), 64'h7);
    end
    chk("stall_overrun_sticky", 64'(overrun), 64'd1);

    // Reset in the middle of a session.
    do_start();
    for (int k = 0; k < 13; k++) send(8'(k), 0);
    reset = 1'b1;
    tick();
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_mem_en", 64'(mem_en), 64'd0);
    chk("midrst_mem_we", 64'(mem_we), 64'd0);
    chk("midrst_addr", 64'(mem_addr), 64'd0);
    chk("midrst_wdata", 64'(mem_wdata), 64'd0);
    chk("midrst_ww", 64'(words_written), 64'd0);
    reset = 1'b0;
    en_count = 0;
    repeat (30) tick();
    chk("midrst_no_write", 64'(en_count), 64'd0);
    run_vec(100, tab[0]);

    // Randomized sessions against the queue-based model.
    for (int it = 0; it < 12; it++) begin
      int n;
      n = $urandom_range(40, 5);
      rnd_bytes.delete();
      rnd_gaps.delete();
      for (int k = 0; k < n; k++) begin
        int r;
        rnd_bytes.push_back(8'($urandom_range(255, 0)));
        r = $urandom_range(9, 0);
        if (r < 6)       rnd_gaps.push_back(r % 4);
        else if (r == 6) rnd_gaps.push_back(15);
        else if (r == 7) rnd_gaps.push_back(16);
        else if (r == 8) rnd_gaps.push_back(17);
        else             rnd_gaps.push_back(25);
      end

      mq_le.delete();
      mq_be.delete();
      part_q.delete();
      model_nw = 0;
      for (int k = 0; k < n; k++) begin
        if (model_nw < 8) begin
          part_q.push_back(rnd_bytes[k]);
          if (part_q.size() == 4) model_emit();
        end
        if (rnd_gaps[k] >= 16 && part_q.size() > 0) model_emit();
      end
      if (part_q.size() > 0) model_emit();

      do_start();
      for (int k = 0; k < n; k++) send(rnd_bytes[k], rnd_gaps[k]);
      repeat (40) tick();

      chk($sformatf("rnd%0d_count", it), 64'(wq.size()), 64'(mq_le.size()));
      chk($sformatf("rnd%0d_be_count", it), 64'(bq.size()), 64'(mq_be.size()));
      for (int k = 0; k < wq.size() && k < mq_le.size(); k++) begin
        chk($sformatf("rnd%0d_w%0d_addr_data", it, k),
            {wq[k].addr, wq[k].data}, {mq_le[k].addr, mq_le[k].data});
        chk($sformatf("rnd%0d_w%0d_we", it, k), 64'(wq[k].we), 64'(mq_le[k].we));
      end
      for (int k = 0; k < bq.size() && k < mq_be.size(); k++) begin
        chk($sformatf("rnd%0d_b%0d_addr_data", it, k),
            {bq[k].addr, bq[k].data}, {mq_be[k].addr, mq_be[k].data});
        chk($sformatf("rnd%0d_b%0d_we", it, k), 64'(bq[k].we), 64'(mq_be[k].we));
      end
      chk($sformatf("rnd%0d_ww", it), 64'(words_written), 64'(model_nw));
      chk($sformatf("rnd%0d_done", it), 64'(done), 64'(model_nw == 8));
      chk($sformatf("rnd%0d_busy", it), 64'(busy), 64'(model_nw != 8));
      chk($sformatf("rnd%0d_overrun", it), 64'(overrun), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
